// File: rtl/nwrite_tx_engine.sv
// nwrite_tx_engine: reads local memory over AXI4 and emits SRIO NWRITE packets on the ireq stream
module nwrite_tx_engine #(
  parameter int unsigned MAX_PKT_BYTES = 256,
  parameter logic [1:0]  PRIO          = 2'b01,
  parameter logic        CRF           = 1'b0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_src_addr,
  input  logic [31:0] cmd_dst_addr,
  input  logic [15:0] cmd_len,
  input  logic [15:0] src_id,
  input  logic [15:0] dest_id,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [63:0] m_axis_ireq_tdata,
  output logic [7:0]  m_axis_ireq_tkeep,
  output logic        m_axis_ireq_tlast,
  output logic [31:0] m_axis_ireq_tuser,
  output logic        m_axis_ireq_tvalid,
  input  logic        m_axis_ireq_tready
);
  typedef enum logic [2:0] {IDLE, CALC, AR, HDR, DATA} state_t;
  state_t      state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, ids_q, ids_d;
  logic [16:0] rem_q, rem_d, pkt_q, pkt_d, room, cap;
  logic [7:0]  tid_q, tid_d;
  logic        err_q, err_d, done_q, done_d;
  logic        accept, beat;
  logic [63:0] swp;
  assign cmd_ready = (state_q == IDLE) & ~areset;
  assign accept    = cmd_valid & cmd_ready;
  assign beat      = (state_q == DATA) & m_axi_rvalid & m_axis_ireq_tready;
  // bytes left before the next local 4 KB boundary
  assign room = 17'd4096 - {5'd0, src_q[11:0]};
  assign cap  = rem_q < 17'(MAX_PKT_BYTES) ? rem_q : 17'(MAX_PKT_BYTES);
  for (genvar g = 0; g < 8; g++) begin : g_swap
    assign swp[8*g +: 8] = m_axi_rdata[56-8*g +: 8];
  end
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    ids_d   = ids_q;
    rem_d   = rem_q;
    pkt_d   = pkt_q;
    tid_d   = tid_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        src_d   = cmd_src_addr & ~32'h7;
        dst_d   = cmd_dst_addr & ~32'h7;
        rem_d   = {1'b0, cmd_len | 16'h7} + 17'd1;
        ids_d   = {src_id, dest_id};
        err_d   = 1'b0;
        state_d = CALC;
      end
      CALC: begin
        pkt_d   = room < cap ? room : cap;
        state_d = AR;
      end
      AR:   state_d = m_axi_arready ? HDR : AR;
      HDR:  if (m_axis_ireq_tready) begin
        tid_d   = tid_q + 8'd1;
        state_d = DATA;
      end
      DATA: if (beat) begin
        err_d = err_q | (|m_axi_rresp);
        if (m_axi_rlast) begin
          src_d   = src_q + {15'd0, pkt_q};
          dst_d   = dst_q + {15'd0, pkt_q};
          rem_d   = rem_q - pkt_q;
          done_d  = rem_q == pkt_q;
          state_d = rem_q == pkt_q ? IDLE : CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      ids_q   <= '0;
      rem_q   <= '0;
      pkt_q   <= '0;
      tid_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      ids_q   <= ids_d;
      rem_q   <= rem_d;
      pkt_q   <= pkt_d;
      tid_q   <= tid_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end
  assign busy               = state_q != IDLE;
  assign done               = done_q;
  assign err                = err_q;
  assign m_axi_araddr       = src_q;
  assign m_axi_arlen        = pkt_q[10:3] - 8'd1;
  assign m_axi_arsize       = 3'b011;
  assign m_axi_arburst      = 2'b01;
  assign m_axi_arvalid      = state_q == AR;
  assign m_axi_rready       = (state_q == DATA) & m_axis_ireq_tready;
  assign m_axis_ireq_tvalid = (state_q == HDR) | ((state_q == DATA) & m_axi_rvalid);
  assign m_axis_ireq_tdata  = state_q == HDR ?
    {tid_q, 8'h54, PRIO, CRF, 1'b0, pkt_q[7:0] - 8'd1, 4'h0, dst_q} : swp;
  assign m_axis_ireq_tkeep  = 8'hFF;
  assign m_axis_ireq_tlast  = (state_q == DATA) & m_axi_rlast;
  assign m_axis_ireq_tuser  = ids_q;
endmodule

// File: tb/tb_nwrite_tx_engine.sv
// tb_nwrite_tx_engine: random-traffic bench with a packet-list reference model and a per-cycle checker
module tb_nwrite_tx_engine;
  logic        aclk, areset, cmd_valid, cmd_ready, busy, done, err;
  logic [31:0] cmd_src_addr, cmd_dst_addr;
  logic [15:0] cmd_len, src_id, dest_id;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst, m_axi_rresp;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axi_rdata, m_axis_ireq_tdata;
  logic [7:0]  m_axis_ireq_tkeep;
  logic        m_axis_ireq_tlast, m_axis_ireq_tvalid, m_axis_ireq_tready;
  logic [31:0] m_axis_ireq_tuser;

  nwrite_tx_engine dut (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
    .src_id(src_id), .dest_id(dest_id), .busy(busy), .done(done), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_ireq_tdata(m_axis_ireq_tdata), .m_axis_ireq_tkeep(m_axis_ireq_tkeep),
    .m_axis_ireq_tlast(m_axis_ireq_tlast), .m_axis_ireq_tuser(m_axis_ireq_tuser),
    .m_axis_ireq_tvalid(m_axis_ireq_tvalid), .m_axis_ireq_tready(m_axis_ireq_tready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic [31:0] u;
    logic        h;
    logic        f;
  } tbeat_t;

  tbeat_t      exp_t[$];
  logic [39:0] exp_ar[$], obs_ar[$];
  logic        exp_err[$];
  logic [63:0] obs_hdr[$], obs_dat[$];
  int          n_chk = 0, n_fail = 0, done_cnt = 0;
  int          t_pct = 100, ar_pct = 100, rv_pct = 100;
  logic [7:0]  tid_m = 8'd0;
  logic        exp_busy = 1'b0, exp_done = 1'b0;
  bit          ar_hs = 0, r_hs = 0, slave_flush = 0;
  logic [39:0] ar_s;
  logic [31:0] bad_addr = 32'h1;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [63:0] mem(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a * 32'h0101_0101 + 32'h1234_5678};
  endfunction

  function automatic logic [63:0] swap8(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) y[8*i +: 8] = x[8*(7-i) +: 8];
    return y;
  endfunction

  // Whole command expanded into its AR list and ireq beat list at accept time
  task automatic model_cmd();
    logic [31:0] s, d, a;
    int rem, pkt, room, nb;
    logic e;
    tbeat_t b;
    s = cmd_src_addr & ~32'h7;
    d = cmd_dst_addr & ~32'h7;
    rem = int'({cmd_len[15:3], 3'b111}) + 1;
    e = 1'b0;
    while (rem > 0) begin
      room = 4096 - int'(s % 4096);
      pkt = rem;
      if (pkt > 256) pkt = 256;
      if (pkt > room) pkt = room;
      nb = pkt / 8;
      exp_ar.push_back({s, 8'(nb - 1)});
      b.d = {tid_m, 8'h54, 2'b01, 1'b0, 1'b0, 8'(pkt - 1), 4'h0, d};
      b.l = 1'b0; b.u = {src_id, dest_id}; b.h = 1'b1; b.f = 1'b0;
      exp_t.push_back(b);
      tid_m = tid_m + 8'd1;
      for (int i = 0; i < nb; i++) begin
        a = s + 32'(8 * i);
        if (a == bad_addr) e = 1'b1;
        b.d = swap8(mem(a));
        b.l = (i == nb - 1);
        b.h = 1'b0;
        b.f = b.l && (rem == pkt);
        exp_t.push_back(b);
      end
      s = s + 32'(pkt);
      d = d + 32'(pkt);
      rem = rem - pkt;
    end
    exp_err.push_back(e);
  endtask

  // Per-cycle checker, sampling at the falling edge
  initial begin
    tbeat_t b;
    logic pst;
    logic [63:0] pd;
    logic [31:0] pu;
    pst = 1'b0; pd = '0; pu = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_t.delete(); exp_ar.delete(); exp_err.delete();
        tid_m = 8'd0; exp_busy = 1'b0; exp_done = 1'b0;
        ar_hs = 0; r_hs = 0; slave_flush = 1; pst = 1'b0;
      end else begin
        chk("done", done, exp_done);
        chk("busy", busy, exp_busy);
        chk("cmd_ready", cmd_ready, !exp_busy);
        if (done) begin
          done_cnt++;
          if (exp_err.size() > 0) chk("err_at_done", err, exp_err.pop_front());
        end
        exp_done = 1'b0;
        if (pst) begin
          chk("tvalid_hold", m_axis_ireq_tvalid, 1'b1);
          chk("tdata_hold", m_axis_ireq_tdata, pd);
          chk("tuser_hold", m_axis_ireq_tuser, pu);
        end
        if (m_axi_rready) chk("rready_needs_tready", m_axis_ireq_tready, 1'b1);
        if (m_axi_rvalid && m_axi_rready) chk("r_passthru_tvalid", m_axis_ireq_tvalid, 1'b1);
        if (cmd_valid && cmd_ready) begin
          model_cmd();
          exp_busy = 1'b1;
        end
        ar_hs = m_axi_arvalid && m_axi_arready;
        ar_s = {m_axi_araddr, m_axi_arlen};
        if (ar_hs) begin
          obs_ar.push_back(ar_s);
          if (exp_ar.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_ar: got %h expected none", ar_s);
          end else begin
            chk("araddr_arlen", ar_s, exp_ar.pop_front());
            chk("arsize", m_axi_arsize, 3'b011);
            chk("arburst", m_axi_arburst, 2'b01);
          end
        end
        r_hs = m_axi_rvalid && m_axi_rready;
        if (m_axis_ireq_tvalid && m_axis_ireq_tready) begin
          if (exp_t.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_beat: got %h expected none", m_axis_ireq_tdata);
          end else begin
            b = exp_t.pop_front();
            chk(b.h ? "hdr_tdata" : "beat_tdata", m_axis_ireq_tdata, b.d);
            chk("tlast", m_axis_ireq_tlast, b.l);
            chk("tuser", m_axis_ireq_tuser, b.u);
            chk("tkeep", m_axis_ireq_tkeep, 8'hFF);
            if (b.h) obs_hdr.push_back(m_axis_ireq_tdata);
            else obs_dat.push_back(m_axis_ireq_tdata);
            if (b.f) begin
              exp_done = 1'b1;
              exp_busy = 1'b0;
            end
          end
        end
        pst = m_axis_ireq_tvalid && !m_axis_ireq_tready;
        pd = m_axis_ireq_tdata;
        pu = m_axis_ireq_tuser;
      end
    end
  end

  // AXI read slave and ireq sink with random throttling
  initial begin
    logic [31:0] bq_a[$];
    logic [7:0]  bq_l[$];
    logic [31:0] a;
    int beat_i;
    beat_i = 0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axis_ireq_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (slave_flush) begin
        bq_a.delete(); bq_l.delete();
        beat_i = 0;
        m_axi_rvalid = 1'b0;
        slave_flush = 0;
      end else begin
        if (ar_hs) begin
          bq_a.push_back(ar_s[39:8]);
          bq_l.push_back(ar_s[7:0]);
        end
        if (r_hs && bq_l.size() > 0) begin
          if (beat_i == int'(bq_l[0])) begin
            void'(bq_a.pop_front());
            void'(bq_l.pop_front());
            beat_i = 0;
          end else beat_i++;
        end
        if (!(m_axi_rvalid && !r_hs)) begin
          if (bq_a.size() > 0 && $urandom_range(99, 0) < rv_pct) begin
            a = bq_a[0] + 32'(8 * beat_i);
            m_axi_rdata = mem(a);
            m_axi_rlast = beat_i == int'(bq_l[0]);
            m_axi_rresp = a == bad_addr ? 2'b10 : 2'b00;
            m_axi_rvalid = 1'b1;
          end else m_axi_rvalid = 1'b0;
        end
      end
      m_axi_arready = $urandom_range(99, 0) < ar_pct;
      m_axis_ireq_tready = $urandom_range(99, 0) < t_pct;
    end
  end

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    bit ok;
    ok = 0;
    cmd_src_addr = s; cmd_dst_addr = d; cmd_len = l;
    src_id = 16'($urandom); dest_id = 16'($urandom);
    cmd_valid = 1'b1;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge aclk);
      ok = cmd_ready;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL cmd_accept_timeout: got no cmd_ready expected accept");
    end
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    bit ok;
    ok = 0;
    for (int k = 0; k < 6000 && !ok; k++) begin
      @(negedge aclk);
      #1;
      ok = done_cnt > start;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done expected done pulse");
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    int st;
    st = done_cnt;
    issue(s, d, l);
    wait_done(st);
  endtask

  task automatic clear_logs();
    obs_ar.delete(); obs_hdr.delete(); obs_dat.delete();
  endtask

  initial begin
    logic [31:0] s;
    int nb, st;
    bit ok;
    areset = 1'b1; cmd_valid = 1'b0;
    cmd_src_addr = '0; cmd_dst_addr = '0; cmd_len = '0; src_id = '0; dest_id = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", m_axis_ireq_tvalid, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);
    @(posedge aclk);
    #1;

    clear_logs();
    run_cmd(32'h0000_1000, 32'h8000_0000, 16'd63);
    chk("t1_ar", obs_ar[0], {32'h1000, 8'd7});
    chk("t1_hdr", obs_hdr[0], 64'h0054_43F0_8000_0000);
    chk("t1_beat0", obs_dat[0], 64'h7866_4422_EFAE_ADDE);
    chk("t1_beats", 64'(obs_dat.size()), 64'd8);

    t_pct = 70; ar_pct = 60; rv_pct = 70;
    clear_logs();
    run_cmd(32'h2000, 32'h4000, 16'd511);
    chk("t2_ar_count", 64'(obs_ar.size()), 64'd2);
    chk("t2_ar0", obs_ar[0], {32'h2000, 8'd31});
    chk("t2_ar1", obs_ar[1], {32'h2100, 8'd31});
    chk("t2_dst0", obs_hdr[0][31:0], 32'h4000);
    chk("t2_dst1", obs_hdr[1][31:0], 32'h4100);
    chk("t2_tid0", obs_hdr[0][63:56], 8'd1);
    chk("t2_tid1", obs_hdr[1][63:56], 8'd2);

    clear_logs();
    run_cmd(32'h0FC0, 32'h9000, 16'd127);
    chk("t3_ar0", obs_ar[0], {32'h0FC0, 8'd7});
    chk("t3_ar1", obs_ar[1], {32'h1000, 8'd7});
    chk("t3_size0", obs_hdr[0][43:36], 8'd63);
    chk("t3_dst1", obs_hdr[1][31:0], 32'h9040);

    t_pct = 50; rv_pct = 50;
    clear_logs();
    run_cmd(32'h3000, 32'h5000, 16'd255);
    chk("t4_ar", obs_ar[0], {32'h3000, 8'd31});
    chk("t4_beats", 64'(obs_dat.size()), 64'd32);

    bad_addr = 32'h6010;
    run_cmd(32'h6000, 32'h7000, 16'd63);
    chk("t5_err_sticky", err, 1'b1);
    bad_addr = 32'h1;
    st = done_cnt;
    issue(32'h6100, 32'h7100, 16'd63);
    chk("t5_err_cleared", err, 1'b0);
    wait_done(st);

    t_pct = 100; ar_pct = 100; rv_pct = 100;
    clear_logs();
    issue(32'h8000, 32'hA000, 16'd63);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge aclk);
      #1;
      ok = obs_dat.size() >= 3;
    end
    chk("t6_reached_beat3", 64'(ok), 64'd1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("t6_tvalid", m_axis_ireq_tvalid, 1'b0);
    chk("t6_arvalid", m_axi_arvalid, 1'b0);
    chk("t6_rready", m_axi_rready, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cmd_ready", cmd_ready, 1'b1);
    @(posedge aclk);
    #1;
    clear_logs();
    run_cmd(32'hB000, 32'hC000, 16'd63);
    chk("t6_tid_reset", obs_hdr[0][63:56], 8'd0);

    t_pct = 60; ar_pct = 50; rv_pct = 60;
    clear_logs();
    run_cmd(32'hFFFF_FFC5, 32'hFFFF_FFF8, 16'd255);
    chk("wrap_ar0", obs_ar[0], {32'hFFFF_FFC0, 8'd7});
    chk("wrap_ar1", obs_ar[1], {32'h0000_0000, 8'd23});
    chk("wrap_dst1", obs_hdr[1][31:0], 32'h0000_0038);

    for (int n = 0; n < 25; n++) begin
      t_pct = $urandom_range(100, 30);
      ar_pct = $urandom_range(100, 30);
      rv_pct = $urandom_range(100, 30);
      s = $urandom;
      if ($urandom_range(1, 0) == 1) s[11:0] = 12'hF00 | 12'($urandom_range(255, 0));
      cmd_len = 16'($urandom_range(1535, 0));
      nb = (int'(cmd_len) | 7) / 8 + 1;
      bad_addr = $urandom_range(2, 0) == 0 ? (s & ~32'h7) + 32'(8 * $urandom_range(nb - 1, 0)) : 32'h1;
      run_cmd(s, $urandom, cmd_len);
    end
    bad_addr = 32'h1;
    repeat (5) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
